// File: rtl/traffic_intersection_fsm.sv
// traffic_intersection_fsm: round-robin multi-phase junction controller with ped extension and green hold
module traffic_intersection_fsm #(
  parameter int NUM_PHASES = 2,
  parameter int TIME_W     = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PHASES*TIME_W-1:0] green_time,
  input  logic [NUM_PHASES*TIME_W-1:0] yellow_time,
  input  logic [TIME_W-1:0]            all_red_time,
  input  logic [TIME_W-1:0]            ped_extension,
  input  logic [NUM_PHASES-1:0]        ped_request,
  input  logic                         hold,
  output logic [3*NUM_PHASES-1:0]      lights,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic [NUM_PHASES-1:0]        ped_walk,
  output logic [NUM_PHASES-1:0]        ped_pending,
  output logic                         error
);
  localparam int PW = $clog2(NUM_PHASES);
  typedef enum logic [1:0] {ALL_RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2} state_t;
  state_t                  state;
  logic [TIME_W:0]         timer;
  logic                    serving;
  logic [TIME_W-1:0]       g_sel, y_sel;
  logic [NUM_PHASES-1:0]   p_mask;
  logic                    last;
  assign g_sel  = green_time[active_phase*TIME_W +: TIME_W];
  assign y_sel  = yellow_time[active_phase*TIME_W +: TIME_W];
  assign p_mask = NUM_PHASES'(1) << active_phase;
  assign last   = active_phase == PW'(NUM_PHASES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ALL_RED;
      timer        <= '0;
      active_phase <= '0;
      ped_pending  <= '0;
      serving      <= 1'b0;
      error        <= 1'b0;
    end else begin
      // a request arriving on the clearing edge survives, so it is served next time round
      ped_pending <= (ped_pending & ~((state == ALL_RED && timer == '0) ? p_mask : '0)) | ped_request;
      case (state)
        ALL_RED:
          if (timer == '0) begin
            state   <= GREEN;
            serving <= ped_pending[active_phase];
            timer   <= ped_pending[active_phase] ? {1'b0, g_sel} + {1'b0, ped_extension} : {1'b0, g_sel};
          end else timer <= timer - 1'b1;
        GREEN:
          if (!hold) begin
            if (timer == '0) begin
              state   <= YELLOW;
              timer   <= {1'b0, y_sel};
              serving <= 1'b0;
            end else timer <= timer - 1'b1;
          end
        YELLOW:
          if (timer == '0) begin
            state        <= ALL_RED;
            timer        <= {1'b0, all_red_time};
            active_phase <= last ? '0 : active_phase + 1'b1;
          end else timer <= timer - 1'b1;
        default: begin
          state <= ALL_RED;
          timer <= '0;
          error <= 1'b1;
        end
      endcase
    end
  end
  assign ped_walk = (state == GREEN && serving) ? p_mask : '0;
  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_lamp
    logic sel;
    assign sel = active_phase == PW'(i);
    assign lights[i*3 +: 3] = (sel && state == GREEN) ? 3'b001 : (sel && state == YELLOW) ? 3'b010 : 3'b100;
  end
endmodule

// File: tb/tb_traffic_intersection_fsm.sv
// tb_traffic_intersection_fsm: directed checks of phase timing, ped extension, hold and 4-phase rotation
module tb_traffic_intersection_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] gt2, yt2;
  logic [5:0]  ar2, ext2;
  logic [1:0]  req2;
  logic        hold2, rst2;
  logic [5:0]  l2;
  logic        ap2;
  logic [1:0]  w2, pd2;
  logic        er2;

  logic [23:0] gt4, yt4;
  logic [5:0]  ar4, ext4;
  logic [3:0]  req4;
  logic        hold4, rst4;
  logic [11:0] l4;
  logic [1:0]  ap4;
  logic [3:0]  w4, pd4;
  logic        er4;

  traffic_intersection_fsm #(.NUM_PHASES(2), .TIME_W(6)) dut2 (
    .clk(clk), .reset(rst2), .green_time(gt2), .yellow_time(yt2), .all_red_time(ar2),
    .ped_extension(ext2), .ped_request(req2), .hold(hold2), .lights(l2), .active_phase(ap2),
    .ped_walk(w2), .ped_pending(pd2), .error(er2));

  traffic_intersection_fsm #(.NUM_PHASES(4), .TIME_W(6)) dut4 (
    .clk(clk), .reset(rst4), .green_time(gt4), .yellow_time(yt4), .all_red_time(ar4),
    .ped_extension(ext4), .ped_request(req4), .hold(hold4), .lights(l4), .active_phase(ap4),
    .ped_walk(w4), .ped_pending(pd4), .error(er4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  localparam logic [5:0] AR = 6'b100100, G0 = 6'b100001, Y0 = 6'b100010,
                         G1 = 6'b001100, Y1 = 6'b010100;

  task automatic seg(input string tag, input logic [5:0] l, input logic p,
                     input logic [1:0] w, input logic [1:0] pd, input int n);
    for (int k = 0; k < n; k++) begin
      chk(tag, 32'({l2, ap2, w2, pd2}), 32'({l, p, w, pd}));
      @(negedge clk);
    end
  endtask

  task automatic reset2();
    rst2 = 1'b1;
    @(negedge clk);
    chk("rst2", 32'({l2, ap2, w2, pd2, er2}), 32'({AR, 1'b0, 2'b00, 2'b00, 1'b0}));
    @(negedge clk);
    rst2 = 1'b0;
  endtask

  function automatic logic [11:0] lamp4(input int i, input logic [2:0] c);
    logic [11:0] v;
    v = {4{3'b100}};
    v[i*3 +: 3] = c;
    return v;
  endfunction

  task automatic seg4(input string tag, input logic [11:0] l, input logic [1:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      chk(tag, 32'({l4, ap4}), 32'({l, p}));
      @(negedge clk);
    end
  endtask

  // no two approaches may ever show anything but red at once
  always @(negedge clk) begin
    int c2, c4;
    c2 = 0;
    c4 = 0;
    for (int i = 0; i < 2; i++) c2 += int'(l2[i*3 +: 3] != 3'b100);
    for (int i = 0; i < 4; i++) c4 += int'(l4[i*3 +: 3] != 3'b100);
    chk("mutex", 32'(c2 > 1 || c4 > 1), 32'd0);
  end

  int g4[4] = '{1, 2, 3, 4};
  int y4[4] = '{2, 1, 2, 1};

  initial begin
    rst2 = 1'b1; rst4 = 1'b1;
    gt2 = {6'd5, 6'd3}; yt2 = {6'd2, 6'd1}; ar2 = 6'd1; ext2 = 6'd4; req2 = '0; hold2 = 1'b0;
    gt4 = {6'd4, 6'd3, 6'd2, 6'd1}; yt4 = {6'd1, 6'd2, 6'd1, 6'd2}; ar4 = 6'd0; ext4 = 6'd0;
    req4 = '0; hold4 = 1'b0;

    // plain rotation, wrap 1 -> 0
    reset2();
    seg("s1_ar", AR, 0, 0, 0, 1);
    seg("s1_g0", G0, 0, 0, 0, 4);
    seg("s1_y0", Y0, 0, 0, 0, 2);
    seg("s1_ar1", AR, 1, 0, 0, 2);
    seg("s1_g1", G1, 1, 0, 0, 6);
    seg("s1_y1", Y1, 1, 0, 0, 3);
    seg("s1_ar0", AR, 0, 0, 0, 2);
    seg("s1_g0b", G0, 0, 0, 0, 4);

    // ped pulse for phase 1 during phase 0 green
    reset2();
    seg("s2_ar", AR, 0, 0, 0, 1);
    req2 = 2'b10;
    seg("s2_g0a", G0, 0, 0, 0, 1);
    req2 = 2'b00;
    seg("s2_g0", G0, 0, 0, 2'b10, 3);
    seg("s2_y0", Y0, 0, 0, 2'b10, 2);
    seg("s2_ar1", AR, 1, 0, 2'b10, 2);
    seg("s2_g1", G1, 1, 2'b10, 0, 10);
    seg("s2_y1", Y1, 1, 0, 0, 3);
    seg("s2_ar0", AR, 0, 0, 0, 2);

    // request held across phase 0 clearing edge stays pending
    reset2();
    req2 = 2'b01;
    seg("s3_ar", AR, 0, 0, 0, 1);
    seg("s3_g0", G0, 0, 0, 2'b01, 4);
    seg("s3_y0", Y0, 0, 0, 2'b01, 2);
    seg("s3_ar1", AR, 1, 0, 2'b01, 2);
    seg("s3_g1", G1, 1, 0, 2'b01, 6);
    seg("s3_y1", Y1, 1, 0, 2'b01, 3);
    seg("s3_ar0", AR, 0, 0, 2'b01, 2);
    seg("s3_g0x", G0, 0, 2'b01, 2'b01, 1);
    req2 = 2'b00;
    seg("s3_g0x", G0, 0, 2'b01, 2'b01, 7);
    seg("s3_y0b", Y0, 0, 0, 2'b01, 2);
    seg("s3_ar1b", AR, 1, 0, 2'b01, 2);
    seg("s3_g1b", G1, 1, 0, 2'b01, 6);
    seg("s3_y1b", Y1, 1, 0, 2'b01, 3);
    seg("s3_ar0b", AR, 0, 0, 2'b01, 2);
    seg("s3_g0y", G0, 0, 2'b01, 0, 8);
    seg("s3_y0c", Y0, 0, 0, 0, 2);

    // hold stretches green by 7, is ignored in yellow
    reset2();
    seg("s4_ar", AR, 0, 0, 0, 1);
    seg("s4_g0", G0, 0, 0, 0, 3);
    hold2 = 1'b1;
    seg("s4_hold", G0, 0, 0, 0, 7);
    hold2 = 1'b0;
    seg("s4_g0e", G0, 0, 0, 0, 1);
    hold2 = 1'b1;
    seg("s4_y0", Y0, 0, 0, 0, 2);
    seg("s4_ar1", AR, 1, 0, 0, 1);
    hold2 = 1'b0;
    seg("s4_ar1b", AR, 1, 0, 0, 1);
    seg("s4_g1", G1, 1, 0, 0, 1);

    // maximum extended green, then async reset mid-yellow
    gt2 = {6'h3F, 6'd3}; ext2 = 6'h3F;
    reset2();
    req2 = 2'b10;
    seg("s5_ar", AR, 0, 0, 0, 1);
    req2 = 2'b00;
    seg("s5_g0", G0, 0, 0, 2'b10, 4);
    seg("s5_y0", Y0, 0, 0, 2'b10, 2);
    seg("s5_ar1", AR, 1, 0, 2'b10, 2);
    req2 = 2'b01;
    seg("s5_g1a", G1, 1, 2'b10, 0, 1);
    req2 = 2'b00;
    seg("s5_g1", G1, 1, 2'b10, 2'b01, 126);
    seg("s5_y1", Y1, 1, 0, 2'b01, 1);
    rst2 = 1'b1;
    #1;
    chk("s5_rst", 32'({l2, ap2, w2, pd2}), 32'({AR, 1'b0, 2'b00, 2'b00}));
    @(negedge clk);
    rst2 = 1'b0;
    chk("err2", 32'(er2), 32'd0);

    // four-phase round robin
    @(negedge clk);
    chk("rst4", 32'({l4, ap4, w4, pd4, er4}), 32'({lamp4(0, 3'b100), 2'd0, 4'd0, 4'd0, 1'b0}));
    @(negedge clk);
    rst4 = 1'b0;
    seg4("s6_ar", lamp4(0, 3'b100), 2'd0, 1);
    for (int r = 0; r < 5; r++) begin
      int i;
      i = r % 4;
      seg4("s6_g", lamp4(i, 3'b001), 2'(i), g4[i] + 1);
      seg4("s6_y", lamp4(i, 3'b010), 2'(i), y4[i] + 1);
      seg4("s6_ar", lamp4(i, 3'b100), 2'((i + 1) % 4), 1);
    end
    chk("err4", 32'(er4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
